// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared single-cycle ALU.
// Each accepted operation runs IDLE -> EXEC -> RESP: operands are latched on accept,
// presented to the ALU for one cycle, and the registered result is returned with a
// one-cycle completion pulse to the requester that issued it.
module alu_arbiter #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req0_alu_op,
    input  logic [1:0]        req1_alu_op,
    input  logic [9:0]        req0_funct,
    input  logic [9:0]        req1_funct,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              alu_en,
    output logic [1:0]        alu_op_o,
    output logic [9:0]        funct_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    output logic [1:0]        resp_valid,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_zero,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q, state_d;
    logic              last_q;      // id of the most recently granted requester
    logic              id_q;        // id of the in-flight operation
    logic [1:0]        op_q;
    logic [9:0]        funct_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;

    logic [1:0]        grant;
    logic              accept;
    logic              sel_id;

    // Pick a requester: a lone request always wins; on a tie either requester 0
    // (fixed mode) or the one that was not granted last (round-robin).
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (FIXED_PRIO != 0) begin
                    grant = 2'b01;
                end else begin
                    grant = last_q ? 2'b01 : 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    // Handshake and next-state decode.
    always_comb begin
        req_ready = (state_q == StIdle) ? grant : 2'b00;
        accept    = |(req_valid & req_ready);
        sel_id    = req_ready[1];
        state_d   = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, round-robin pointer and latched operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            op_q    <= '0;
            funct_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q  <= sel_id;
                id_q    <= sel_id;
                op_q    <= sel_id ? req1_alu_op : req0_alu_op;
                funct_q <= sel_id ? req1_funct  : req0_funct;
                a_q     <= sel_id ? req1_a      : req0_a;
                b_q     <= sel_id ? req1_b      : req0_b;
            end
        end
    end

    // Capture the ALU output at the end of EXEC; held until the next EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else if (state_q == StExec) begin
            result_q <= alu_result_i;
            zero_q   <= alu_zero_i;
        end
    end

    // ALU drive is gated to EXEC so the shared ALU sees zeros when idle.
    always_comb begin
        alu_en      = (state_q == StExec);
        alu_op_o    = alu_en ? op_q    : 2'b00;
        funct_o     = alu_en ? funct_q : 10'd0;
        alu_a_o     = alu_en ? a_q     : '0;
        alu_b_o     = alu_en ? b_q     : '0;
        resp_valid  = (state_q == StResp) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
        resp_result = result_q;
        resp_zero   = zero_q;
        busy        = (state_q != StIdle);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: one round-robin and one fixed-priority instance share the
// request stimulus; each has its own behavioural ALU. A transaction-level model
// (accept time, latched operation, last winner) predicts every output each cycle.
module tb_alu_arbiter;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic reset;
    logic [1:0]   req_valid;
    logic [1:0]   r0_op, r1_op;
    logic [9:0]   r0_fn, r1_fn;
    logic [W-1:0] r0_a, r0_b, r1_a, r1_b;

    logic [1:0]   rdy   [2];
    logic         aen   [2];
    logic [1:0]   aop   [2];
    logic [9:0]   afn   [2];
    logic [W-1:0] aa    [2];
    logic [W-1:0] ab    [2];
    logic [W-1:0] ares  [2];
    logic         azero [2];
    logic [1:0]   rv    [2];
    logic [W-1:0] rres  [2];
    logic         rzero [2];
    logic         bsy   [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state per instance (0 = round-robin, 1 = fixed priority).
    int           acc_c  [2];
    int           last_m [2];
    int           id_m   [2];
    logic [1:0]   lop    [2];
    logic [9:0]   lfn    [2];
    logic [W-1:0] la     [2];
    logic [W-1:0] lb     [2];
    logic [W-1:0] sres   [2];
    logic         szero  [2];

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_f(input logic [1:0] op, input logic [9:0] f,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: begin
                case (f[2:0])
                    3'd0:    return f[8] ? a - b : a + b;
                    3'd4:    return a ^ b;
                    3'd6:    return a | b;
                    3'd7:    return a & b;
                    default: return a + b;
                endcase
            end
            default: return b;
        endcase
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        assign ares[k]  = alu_f(aop[k], afn[k], aa[k], ab[k]);
        assign azero[k] = (ares[k] == '0);
        alu_arbiter #(.DATA_W(W), .FIXED_PRIO(k)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .req_valid    (req_valid),
            .req_ready    (rdy[k]),
            .req0_alu_op  (r0_op),
            .req1_alu_op  (r1_op),
            .req0_funct   (r0_fn),
            .req1_funct   (r1_fn),
            .req0_a       (r0_a),
            .req0_b       (r0_b),
            .req1_a       (r1_a),
            .req1_b       (r1_b),
            .alu_en       (aen[k]),
            .alu_op_o     (aop[k]),
            .funct_o      (afn[k]),
            .alu_a_o      (aa[k]),
            .alu_b_o      (ab[k]),
            .alu_result_i (ares[k]),
            .alu_zero_i   (azero[k]),
            .resp_valid   (rv[k]),
            .resp_result  (rres[k]),
            .resp_zero    (rzero[k]),
            .busy         (bsy[k])
        );
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[inst%0d] cycle %0d observed=%0h expected=%0h", tag, k, cyc, obs, exp);
        end
    endtask

    function automatic int pick(input int k);
        case (req_valid)
            2'b01:   return 0;
            2'b10:   return 1;
            2'b11:   return (k == 1) ? 0 : 1 - last_m[k];
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            acc_c[k]  = -100;
            last_m[k] = 1;
            id_m[k]   = 0;
            lop[k]    = '0;
            lfn[k]    = '0;
            la[k]     = '0;
            lb[k]     = '0;
            sres[k]   = '0;
            szero[k]  = 1'b0;
        end
    endtask

    task automatic check_inst(input int k);
        bit idle, exec, resp;
        int w;
        idle = (cyc >= acc_c[k] + 3);
        exec = (cyc == acc_c[k] + 1);
        resp = (cyc == acc_c[k] + 2);
        w    = pick(k);
        chk("req_ready",   k, 32'(rdy[k]), (idle && w >= 0) ? 32'(1 << w) : 32'd0);
        chk("alu_en",      k, 32'(aen[k]), 32'(exec));
        chk("alu_op",      k, 32'(aop[k]), exec ? 32'(lop[k]) : 32'd0);
        chk("funct",       k, 32'(afn[k]), exec ? 32'(lfn[k]) : 32'd0);
        chk("alu_a",       k, 32'(aa[k]),  exec ? 32'(la[k])  : 32'd0);
        chk("alu_b",       k, 32'(ab[k]),  exec ? 32'(lb[k])  : 32'd0);
        chk("resp_valid",  k, 32'(rv[k]),  resp ? 32'(1 << id_m[k]) : 32'd0);
        chk("resp_result", k, 32'(rres[k]), 32'(sres[k]));
        chk("resp_zero",   k, 32'(rzero[k]), 32'(szero[k]));
        chk("busy",        k, 32'(bsy[k]), 32'(!idle));
    endtask

    task automatic model_step(input int k);
        int w;
        w = pick(k);
        if (cyc == acc_c[k] + 1) begin
            sres[k]  = alu_f(lop[k], lfn[k], la[k], lb[k]);
            szero[k] = (sres[k] == '0);
        end
        if (cyc >= acc_c[k] + 3 && w >= 0) begin
            acc_c[k]  = cyc;
            last_m[k] = w;
            id_m[k]   = w;
            lop[k]    = (w == 1) ? r1_op : r0_op;
            lfn[k]    = (w == 1) ? r1_fn : r0_fn;
            la[k]     = (w == 1) ? r1_a  : r0_a;
            lb[k]     = (w == 1) ? r1_b  : r0_b;
        end
    endtask

    // One clock cycle: check at the falling edge, advance the model, step past the rise.
    task automatic tick(input bit upd);
        @(negedge clk);
        check_inst(0);
        check_inst(1);
        if (upd) begin
            model_step(0);
            model_step(1);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        tick(1'b0);
        reset = 1'b0;
    endtask

    task automatic set_req(input int r, input logic [1:0] op, input logic [9:0] fn,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (r == 0) begin
            r0_op = op; r0_fn = fn; r0_a = a; r0_b = b;
        end else begin
            r1_op = op; r1_fn = fn; r1_a = a; r1_b = b;
        end
    endtask

    initial begin
        req_valid = 2'b00;
        set_req(0, 2'd0, 10'd0, '0, '0);
        set_req(1, 2'd0, 10'd0, '0, '0);
        do_reset();
        tick(1'b1);

        // Single op from requester 0: 5 + 3.
        set_req(0, 2'd2, 10'd0, 8'd5, 8'd3);
        req_valid = 2'b01;
        tick(1'b1);
        req_valid = 2'b00;
        repeat (3) tick(1'b1);
        chk("single_result", 0, 32'(rres[0]), 32'd8);

        // Tie held for six cycles: alternate in round-robin, requester 0 in fixed mode.
        set_req(0, 2'd0, 10'd0, 8'd10, 8'd20);
        set_req(1, 2'd1, 10'd0, 8'd50, 8'd8);
        req_valid = 2'b11;
        repeat (6) tick(1'b1);
        req_valid = 2'b00;
        repeat (3) tick(1'b1);

        // Requester 1 subtracts to zero.
        set_req(1, 2'd1, 10'd0, 8'd7, 8'd7);
        req_valid = 2'b10;
        tick(1'b1);
        req_valid = 2'b00;
        repeat (2) tick(1'b1);
        chk("sub_zero_flag", 0, 32'(rzero[0]), 32'd1);
        tick(1'b1);

        // Reset while in EXEC, then a tie: requester 0 must win first.
        set_req(0, 2'd0, 10'd0, 8'd1, 8'd2);
        req_valid = 2'b01;
        tick(1'b1);
        req_valid = 2'b00;
        do_reset();
        repeat (2) tick(1'b1);
        req_valid = 2'b11;
        tick(1'b1);
        req_valid = 2'b00;
        repeat (3) tick(1'b1);

        // Operand changes during EXEC do not reach the in-flight operation.
        set_req(0, 2'd2, 10'd0, 8'd5, 8'd3);
        req_valid = 2'b01;
        tick(1'b1);
        r0_a = 8'd9;
        req_valid = 2'b00;
        repeat (3) tick(1'b1);
        chk("latched_operand", 0, 32'(rres[0]), 32'd8);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            for (int r = 0; r < 2; r++) begin
                logic [1:0]   op;
                logic [9:0]   fn;
                logic [W-1:0] a, b;
                op = 2'($urandom_range(0, 3));
                fn = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, 3'($urandom_range(0, 7))};
                a  = W'($urandom);
                b  = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
                set_req(r, op, fn, a, b);
            end
            if ($urandom_range(0, 60) == 0) do_reset();
            else tick(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: operand and result width in bits.
REQ-002 Parameter FIXED_PRIO, default 0: 0 = round-robin arbitration, 1 = requester 0 always wins.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester operation request; bit i = requester i.
REQ-006 req_ready  output  2  per-requester accept; one-hot or zero.
REQ-007 req0_alu_op, req1_alu_op  input  2 each  ALU operation class.
REQ-008 req0_funct, req1_funct  input  10 each  {funct7, funct3}.
REQ-009 req0_a, req0_b, req1_a, req1_b  input  DATA_W each  operands.
REQ-010 alu_en  output  1  shared-ALU operation strobe.
REQ-011 alu_op_o  output  2;  funct_o  output  10;  alu_a_o, alu_b_o  output  DATA_W: shared-ALU inputs.
REQ-012 alu_result_i  input  DATA_W;  alu_zero_i  input  1: combinational ALU result and zero flag.
REQ-013 resp_valid  output  2  one-cycle per-requester completion pulse.
REQ-014 resp_result  output  DATA_W;  resp_zero  output  1: registered result of the completed operation.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, EXEC, RESP; IDLE->EXEC on accept, EXEC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-017 req_ready shall be asserted only in IDLE, combinationally, for exactly the selected requester with req_valid high.
REQ-018 Accept = req_valid[i] & req_ready[i] at a rising edge; opcode, funct, operands and requester id latch into internal registers on that edge.
REQ-019 Single request in IDLE: that requester is selected regardless of priority mode.
REQ-020 Both requesting, FIXED_PRIO=1: requester 0 selected.
REQ-021 Both requesting, FIXED_PRIO=0: requester other than last-granted selected; last-granted pointer updates only on accept.
REQ-022 In EXEC: alu_en=1 and alu_op_o/funct_o/alu_a_o/alu_b_o driven from latched registers; alu_result_i and alu_zero_i captured into resp_result/resp_zero at end of EXEC.
REQ-023 Outside EXEC: alu_en=0 and alu_op_o, funct_o, alu_a_o, alu_b_o driven to zero.
REQ-024 In RESP: resp_valid bit of latched requester id high for exactly one cycle; other bit low.
REQ-025 resp_result/resp_zero shall hold their value until the next EXEC capture.
REQ-026 Latency: accept at edge N -> EXEC in cycle N+1 -> resp_valid in cycle N+2; maximum throughput one operation per 3 cycles.
REQ-027 req_valid changes while not in IDLE shall have no effect; a dropped unaccepted request is simply not served.
REQ-028 Input operand changes after accept shall not alter the in-flight operation.
REQ-029 No requester shall wait more than one competing operation in round-robin mode.

Reset
REQ-030 Reset shall force state IDLE, req_ready per REQ-017 evaluation (IDLE), resp_valid=0, resp_result=0, resp_zero=0, alu_en=0, busy=0, last-granted pointer=1 (requester 0 wins first tie).
REQ-031 Reset asserted mid-operation shall discard the in-flight operation; no resp_valid shall be produced for it.

Verification
REQ-032 Single op: req_valid=01, alu_op=10, funct=0, a=5, b=3 -> req_ready=01 same cycle, alu_en with a=5,b=3 next cycle, resp_valid=01, resp_result=8, resp_zero=0 two cycles after accept.
REQ-033 Tie, round-robin: req_valid=11 held for 6 cycles after reset -> grants 0,1 alternating; resp_valid sequence 01,10.
REQ-034 Tie, FIXED_PRIO=1: req_valid=11 held -> every accept to requester 0; requester 1 never granted.
REQ-035 Subtract to zero: requester 1, alu_op=01, a=7, b=7 -> resp_valid=10, resp_result=0, resp_zero=1.
REQ-036 Reset during EXEC -> next cycle busy=0, alu_en=0, no resp_valid; subsequent request served normally with requester 0 winning tie.
REQ-037 Operand change after accept: a changed 5->9 during EXEC -> result reflects a=5.
